// File: rtl/arb_pkg.sv
// Shared definitions for the VC round-robin arbiter: FSM state encoding and
// default word geometry.
package arb_pkg;

  localparam int DATA_W_DEF   = 6;
  localparam int DEST_BIT_DEF = 4;
  localparam int CNT_W_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    RUN   = 3'b010,
    BLOCK = 3'b100
  } arb_state_e;

endpackage

// File: rtl/rr_grant2.sv
// Two-requester round-robin grant. Purely combinational; the pointer register
// lives in the instantiating module.
module rr_grant2 (
  input  logic [1:0] elig_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // On a tie the requester that did not win last time is served.
  assign grant_o = (&elig_i) ? (last_i ? 2'b01 : 2'b10) : elig_i;

endmodule

// File: rtl/vc_rr_arbiter.sv
// Round-robin scheduler moving words from VC0/VC1 FIFOs to the D0/D1 FIFOs.
// Define ARB_STATS_EN to add per-VC grant counters (cnt_vc0/cnt_vc1).
module vc_rr_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEST_BIT = DEST_BIT_DEF
`ifdef ARB_STATS_EN
  ,
  parameter int CNT_W    = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] d_data,
  output logic              arb_idle
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_vc0,
  output logic [CNT_W-1:0]  cnt_vc1
`endif
);

  arb_state_e        state_q;
  logic              last_q;
  logic              d0_push_q, d1_push_q, arb_idle_q;
  logic [DATA_W-1:0] d_data_q;

  logic [1:0]        elig, grant;
  logic [DATA_W-1:0] win_data;
  logic              vc0_af, vc1_af, both_af, any_data;

  // Almost-full of the destination each head word is heading for.
  assign vc0_af   = vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
  assign vc1_af   = vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
  assign both_af  = d0_almost_full & d1_almost_full;
  assign any_data = ~vc0_empty | ~vc1_empty;

  assign elig[0] = (state_q == RUN) & active_in & ~vc0_empty & ~vc0_af;
  assign elig[1] = (state_q == RUN) & active_in & ~vc1_empty & ~vc1_af;

  rr_grant2 u_grant (
    .elig_i  (elig),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign vc0_pop  = grant[0];
  assign vc1_pop  = grant[1];
  assign win_data = grant[1] ? vc1_data : vc0_data;

  // NOTE: every register below uses non-blocking assignment so that all
  // state updates on an edge see the pre-edge values of each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      arb_idle_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (active_in) begin
            state_q    <= RUN;
            arb_idle_q <= 1'b0;
          end
        end
        RUN: begin
          if (!active_in) begin
            state_q    <= IDLE;
            arb_idle_q <= 1'b1;
          end else if (both_af && any_data) begin
            state_q    <= BLOCK;
          end
        end
        BLOCK: begin
          if (!active_in) begin
            state_q    <= IDLE;
            arb_idle_q <= 1'b1;
          end else if (!both_af) begin
            state_q    <= RUN;
          end
        end
        default: begin
          state_q    <= IDLE;
          arb_idle_q <= 1'b1;
        end
      endcase
    end
  end

  // The push lands one cycle after the pop; reset discards it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      d_data_q  <= '0;
    end else begin
      d0_push_q <= (|grant) & ~win_data[DEST_BIT];
      d1_push_q <= (|grant) &  win_data[DEST_BIT];
      if (|grant) begin
        last_q   <= grant[1];
        d_data_q <= win_data;
      end
    end
  end

  assign d0_push  = d0_push_q;
  assign d1_push  = d1_push_q;
  assign d_data   = d_data_q;
  assign arb_idle = arb_idle_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt_vc0_q, cnt_vc1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_vc0_q <= '0;
      cnt_vc1_q <= '0;
    end else begin
      if (grant[0]) cnt_vc0_q <= cnt_vc0_q + CNT_W'(1);
      if (grant[1]) cnt_vc1_q <= cnt_vc1_q + CNT_W'(1);
    end
  end

  assign cnt_vc0 = cnt_vc0_q;
  assign cnt_vc1 = cnt_vc1_q;
`endif

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Scoreboard bench for vc_rr_arbiter: FIFO models feed the VCs, popped words are
// queued as expected pushes and matched against D0/D1 pushes one cycle later.
module tb_vc_rr_arbiter;

  localparam int DATA_W   = 6;
  localparam int DEST_BIT = 4;
  localparam int CNT_W    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              active_in = 1'b0;
  logic              vc0_empty = 1'b1, vc1_empty = 1'b1;
  logic [DATA_W-1:0] vc0_data = '0, vc1_data = '0;
  logic              d0_af = 1'b0, d1_af = 1'b0;
  logic              vc0_pop, vc1_pop, d0_push, d1_push, arb_idle;
  logic [DATA_W-1:0] d_data;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0]  cnt_vc0, cnt_vc1;
`endif

  vc_rr_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .active_in      (active_in),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_af),
    .d1_almost_full (d1_af),
    .vc0_pop        (vc0_pop),
    .vc1_pop        (vc1_pop),
    .d0_push        (d0_push),
    .d1_push        (d1_push),
    .d_data         (d_data),
    .arb_idle       (arb_idle)
`ifdef ARB_STATS_EN
    ,
    .cnt_vc0        (cnt_vc0),
    .cnt_vc1        (cnt_vc1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              dest;
    logic [DATA_W-1:0] word;
  } exp_t;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] vc0_q[$], vc1_q[$];
  exp_t              exp_q[$];

  task automatic drive_vc();
    vc0_empty = (vc0_q.size() == 0);
    vc1_empty = (vc1_q.size() == 0);
    vc0_data  = (vc0_q.size() != 0) ? vc0_q[0] : '0;
    vc1_data  = (vc1_q.size() != 0) ? vc1_q[0] : '0;
  endtask

  task automatic clear_models();
    vc0_q.delete();
    vc1_q.delete();
    exp_q.delete();
    drive_vc();
  endtask

  // One clock: sample pops mid-cycle, retire popped words into the scoreboard,
  // then compare the registered push just after the edge.
  task automatic step(output logic p0, output logic p1);
    exp_t e;
    @(negedge clk);
    p0 = vc0_pop;
    p1 = vc1_pop;
    if (p0 === 1'b1 && vc0_q.size() != 0) begin
      e.word = vc0_q.pop_front();
      e.dest = e.word[DEST_BIT];
      exp_q.push_back(e);
    end else if (p1 === 1'b1 && vc1_q.size() != 0) begin
      e.word = vc1_q.pop_front();
      e.dest = e.word[DEST_BIT];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (d0_push === 1'b1 || d1_push === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL push_unexpected: got d0/d1_push=%b%b d_data=%h, required no push",
                 d0_push, d1_push, d_data);
      end else begin
        e = exp_q.pop_front();
        if ({d0_push, d1_push, d_data} !== {~e.dest, e.dest, e.word}) begin
          n_fail++;
          $display("FAIL push_word: got d0/d1_push=%b%b d_data=%h, required %b%b %h",
                   d0_push, d1_push, d_data, ~e.dest, e.dest, e.word);
        end
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_fail++;
      $display("FAIL push_missing: got no push, required word %h to D%0d", e.word, e.dest);
    end
    drive_vc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    clear_models();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({d0_push, d1_push, d_data, arb_idle, vc0_pop, vc1_pop} !== {2'b00, 6'h00, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got push=%b%b data=%h idle=%b pop=%b%b, required 00 00 1 00",
               d0_push, d1_push, d_data, arb_idle, vc0_pop, vc1_pop);
    end
`ifdef ARB_STATS_EN
    n_checks++;
    if ({cnt_vc0, cnt_vc1} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d, required 0/0", cnt_vc0, cnt_vc1);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic p0, p1;
    active_in = 1'b1;
    step(p0, p1);
    n_checks++;
    if ({p0, p1, arb_idle} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_start: got pop=%b%b idle=%b, required 00 0", p0, p1, arb_idle);
    end
    vc0_q.push_back(6'h05);
    drive_vc();
    step(p0, p1);
    n_checks++;
    if ({p0, p1, d0_push, d1_push, d_data} !== {4'b1010, 6'h05}) begin
      n_fail++;
      $display("FAIL single_pop_push: got pop=%b%b push=%b%b data=%h, required 10 10 05",
               p0, p1, d0_push, d1_push, d_data);
    end
    step(p0, p1);
    n_checks++;
    if ({p0, p1} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_drained: got pop=%b%b, required 00", p0, p1);
    end
  endtask

  task automatic test_back_to_back();
    logic p0, p1;
    logic [1:0] want;
    do_reset();
    step(p0, p1);
    vc0_q = '{6'h01, 6'h12};
    vc1_q = '{6'h14, 6'h23};
    drive_vc();
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
      step(p0, p1);
      n_checks++;
      if ({p0, p1} !== want) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got pop=%b%b, required %b", i, p0, p1, want);
      end
    end
`ifdef ARB_STATS_EN
    n_checks++;
    if (cnt_vc0 !== 8'd2 || cnt_vc1 !== 8'd2) begin
      n_fail++;
      $display("FAIL rr_counters: got %0d/%0d, required 2/2", cnt_vc0, cnt_vc1);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    logic p0, p1;
    vc0_q = '{6'h2A, 6'h0B};
    drive_vc();
    step(p0, p1);
    @(negedge clk);
    n_checks++;
    if (vc0_pop !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pending_pop: got vc0_pop=%b, required 1", vc0_pop);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({d0_push, d1_push, d_data, arb_idle} !== {2'b00, 6'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: got push=%b%b data=%h idle=%b, required 00 00 1",
               d0_push, d1_push, d_data, arb_idle);
    end
`ifdef ARB_STATS_EN
    n_checks++;
    if ({cnt_vc0, cnt_vc1} !== '0) begin
      n_fail++;
      $display("FAIL mid_counters: got %0d/%0d, required 0/0", cnt_vc0, cnt_vc1);
    end
`endif
    @(posedge clk);
    #1;
    n_checks++;
    if ({d0_push, d1_push, arb_idle} !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_after_edge: got push=%b%b idle=%b, required 00 1", d0_push, d1_push, arb_idle);
    end
    reset = 1'b0;
    clear_models();
  endtask

  task automatic test_almost_full();
    logic p0, p1;
    step(p0, p1);
    vc0_q = '{6'h12};
    vc1_q = '{6'h03};
    d1_af = 1'b1;
    drive_vc();
    step(p0, p1);
    n_checks++;
    if ({p0, p1} !== 2'b01) begin
      n_fail++;
      $display("FAIL af_skip_vc0: got pop=%b%b, required 01", p0, p1);
    end
    step(p0, p1);
    n_checks++;
    if ({p0, p1, arb_idle} !== 3'b000) begin
      n_fail++;
      $display("FAIL af_wait: got pop=%b%b idle=%b, required 00 0", p0, p1, arb_idle);
    end
    d1_af = 1'b0;
    step(p0, p1);
    n_checks++;
    if ({p0, p1, d1_push, d_data} !== {3'b101, 6'h12}) begin
      n_fail++;
      $display("FAIL af_release: got pop=%b%b d1_push=%b data=%h, required 10 1 12",
               p0, p1, d1_push, d_data);
    end
  endtask

  task automatic test_block();
    logic p0, p1;
    logic [1:0] want [5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    vc0_q = '{6'h21};
    vc1_q = '{6'h15};
    d0_af = 1'b1;
    d1_af = 1'b1;
    drive_vc();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) d0_af = 1'b0;
      if (i == 4) d1_af = 1'b0;
      step(p0, p1);
      n_checks++;
      if ({p0, p1} !== want[i]) begin
        n_fail++;
        $display("FAIL block[%0d]: got pop=%b%b, required %b", i, p0, p1, want[i]);
      end
    end
  endtask

  task automatic test_active_drop();
    logic p0, p1;
    vc0_q = '{6'h07, 6'h08};
    drive_vc();
    step(p0, p1);
    n_checks++;
    if ({p0, p1, d0_push, d_data} !== {3'b101, 6'h07}) begin
      n_fail++;
      $display("FAIL drop_push_done: got pop=%b%b d0_push=%b data=%h, required 10 1 07",
               p0, p1, d0_push, d_data);
    end
    active_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(p0, p1);
      n_checks++;
      if ({p0, p1, arb_idle} !== 3'b001) begin
        n_fail++;
        $display("FAIL drop_idle[%0d]: got pop=%b%b idle=%b, required 00 1", i, p0, p1, arb_idle);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_midstream();
    test_almost_full();
    test_block();
    test_active_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
